// File: rtl/decode_pkg.sv
// jpu shared types and RV32I constants.
// Holds the dcd_s decode bundle, opcode/F3/ALU codes and imm formats.
package jpu;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LSH = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        alu_pc;
    logic        alu_imm;
    logic        opi;
    logic        lui;
    logic        j;
    logic        br;
    logic        ld;
    logic        st;
    logic        wb;
    logic        illegal;
  } dcd_s;

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: builds the sign-extended imm for a given format.
// Ports: inst (instruction word), fmt (format select), imm (result).
module imm_gen
  import jpu::*;
(
  input  logic [31:0] inst,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  logic [19:0] sx;
  assign sx = {20{inst[31]}};

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I: imm = {sx, inst[31:20]};
      FMT_S: imm = {sx, inst[31:25], inst[11:7]};
      FMT_B: imm = {sx[18:0], inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'b0};
      FMT_J: imm = {sx[10:0], inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decoder for the ID stage with registered ID/EX copy.
// Ports: clk, rst (async high), en, inst -> dcd (comb), dcd_q (reg).
module decode
  import jpu::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] inst,
  output dcd_s        dcd,
  output dcd_s        dcd_q
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm;
  fmt_e        fmt;

  assign op = inst[6:0];
  assign f3 = inst[14:12];

  // Format select kept apart from the main decode so the
  // imm path is not a loop through one block.
  always_comb begin
    fmt = FMT_R;
    unique case (op)
      OP_OPIMM,
      OP_LOAD,
      OP_JALR:   fmt = FMT_I;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI,
      OP_AUIPC:  fmt = FMT_U;
      OP_JAL:    fmt = FMT_J;
      default:   fmt = FMT_R;
    endcase
  end

  imm_gen u_imm (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  always_comb begin
    dcd        = '0;
    dcd.rd     = inst[11:7];
    dcd.rs1    = inst[19:15];
    dcd.rs2    = inst[24:20];
    dcd.f3     = f3;
    dcd.alu_op = ALU_ADD;
    dcd.imm    = imm;
    unique case (op)
      OP_OP: begin
        dcd.alu_op = {inst[30], f3};
        dcd.wb     = 1'b1;
      end
      OP_OPIMM: begin
        // Only shifts carry the SRA/SRL select in bit 30.
        if (f3 == F3_LSH || f3 == F3_SR)
          dcd.alu_op = {inst[30], f3};
        else
          dcd.alu_op = {1'b0, f3};
        dcd.opi = 1'b1;
        dcd.wb  = 1'b1;
      end
      OP_LOAD: begin
        dcd.alu_imm = 1'b1;
        dcd.ld      = 1'b1;
        dcd.wb      = 1'b1;
      end
      OP_STORE: begin
        dcd.alu_imm = 1'b1;
        dcd.st      = 1'b1;
      end
      OP_BRANCH: begin
        dcd.alu_pc  = 1'b1;
        dcd.alu_imm = 1'b1;
        dcd.br      = 1'b1;
      end
      OP_JAL: begin
        dcd.alu_pc  = 1'b1;
        dcd.alu_imm = 1'b1;
        dcd.j       = 1'b1;
        dcd.wb      = 1'b1;
      end
      OP_JALR: begin
        dcd.alu_imm = 1'b1;
        dcd.j       = 1'b1;
        dcd.wb      = 1'b1;
      end
      OP_LUI: begin
        dcd.alu_imm = 1'b1;
        dcd.lui     = 1'b1;
        dcd.wb      = 1'b1;
      end
      OP_AUIPC: begin
        dcd.alu_pc  = 1'b1;
        dcd.alu_imm = 1'b1;
        dcd.wb      = 1'b1;
      end
      // FENCE/SYSTEM are legal but drive no datapath flags.
      OP_FENCE,
      OP_SYSTEM: ;
      default: dcd.illegal = 1'b1;
    endcase
    if (dcd.rd == 5'd0)
      dcd.wb = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dcd_q <= '0;
    else if (en)
      dcd_q <= dcd;
  end

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode.
// Compares dcd/dcd_q against a spec-level reference model.
module tb_decode;
  import jpu::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] inst;
  dcd_s        dcd;
  dcd_s        dcd_q;

  int n_cmp = 0;
  int n_bad = 0;

  decode dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inst  (inst),
    .dcd   (dcd),
    .dcd_q (dcd_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: immediates by arithmetic shifts/masks on the word,
  // flags by opcode-class membership.
  function automatic dcd_s model(input logic [31:0] i);
    dcd_s d;
    logic [31:0] s;
    logic [6:0]  o;
    bit is_op, is_opi, is_ld, is_st, is_br;
    bit is_jal, is_jalr, is_lui, is_aui, ok;
    s = i;
    o = i[6:0];
    d = '0;
    d.rd  = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.f3  = i[14:12];
    is_op   = (o == 7'h33);
    is_opi  = (o == 7'h13);
    is_ld   = (o == 7'h03);
    is_st   = (o == 7'h23);
    is_br   = (o == 7'h63);
    is_jal  = (o == 7'h6f);
    is_jalr = (o == 7'h67);
    is_lui  = (o == 7'h37);
    is_aui  = (o == 7'h17);
    ok = is_op | is_opi | is_ld | is_st | is_br | is_jal
       | is_jalr | is_lui | is_aui | (o == 7'h0f) | (o == 7'h73);
    if (is_opi | is_ld | is_jalr)
      d.imm = 32'($signed(s) >>> 20);
    else if (is_st)
      d.imm = (32'($signed(s) >>> 20) & ~32'd31) | 32'(i[11:7]);
    else if (is_br)
      d.imm = (32'($signed(s) >>> 19) & 32'hffff_f000)
            | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
            | (32'(i[11:8]) << 1);
    else if (is_lui | is_aui)
      d.imm = i & 32'hffff_f000;
    else if (is_jal)
      d.imm = (32'($signed(s) >>> 11) & 32'hfff0_0000)
            | (i & 32'h000f_f000) | (32'(i[20]) << 11)
            | (32'(i[30:21]) << 1);
    if (is_op || (is_opi && i[13:12] == 2'b01))
      d.alu_op = {i[30], i[14:12]};
    else if (is_opi)
      d.alu_op = {1'b0, i[14:12]};
    d.alu_pc  = is_aui | is_jal | is_br;
    d.alu_imm = is_ld | is_st | is_br | is_jal | is_jalr
              | is_lui | is_aui;
    d.opi = is_opi;
    d.lui = is_lui;
    d.j   = is_jal | is_jalr;
    d.br  = is_br;
    d.ld  = is_ld;
    d.st  = is_st;
    d.wb  = (is_op | is_opi | is_ld | is_jal | is_jalr
            | is_lui | is_aui) && (i[11:7] != 0);
    d.illegal = !ok;
    return d;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f,
            7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 9) < 8)
      w[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 7) == 0)
      w[11:7] = 5'd0;
    return w;
  endfunction

  dcd_s exp_q;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    inst = 32'h0;
    #12;
    chk("reset_q", dcd_q, 64'd0);
    rst = 1'b0;

    inst = 32'h0000_8133; #1;
    chk("add_rd", 64'(dcd.rd), 64'd2);
    chk("add_rs1", 64'(dcd.rs1), 64'd1);
    chk("add_wb", 64'(dcd.wb), 64'd1);
    chk("add_all", dcd, model(inst));

    inst = 32'h0DE0_8113; #1;
    chk("addi_imm", 64'(dcd.imm), 64'h0000_00de);
    chk("addi_opi", 64'(dcd.opi), 64'd1);
    chk("addi_all", dcd, model(inst));

    inst = 32'hF820_9E23; #1;
    chk("sh_imm", 64'(dcd.imm), 64'hffff_ff9c);
    chk("sh_f3", 64'(dcd.f3), 64'(F3_LSH));
    chk("sh_flags", 64'({dcd.alu_imm, dcd.st, dcd.wb}), 64'b110);
    chk("sh_all", dcd, model(inst));

    inst = 32'hFFDF_F0EF; #1;
    chk("jal_imm", 64'(dcd.imm), 64'hffff_fffc);
    chk("jal_flags", 64'({dcd.j, dcd.alu_pc, dcd.wb}), 64'b111);

    inst = 32'h0020_9463; #1;
    chk("bne_imm", 64'(dcd.imm), 64'd8);
    chk("bne_br", 64'({dcd.br, dcd.f3}), 64'b1001);

    inst = 32'h0BEE_F0B7; #1;
    chk("lui_imm", 64'(dcd.imm), 64'h0bee_f000);
    chk("lui_flag", 64'(dcd.lui), 64'd1);

    inst = 32'h0000_0000; #1;
    chk("zero_ill", 64'(dcd.illegal), 64'd1);
    chk("zero_flags", 64'(dcd[9:1]), 64'd0);

    inst = 32'h4010_d093; #1;
    chk("srai_op", 64'(dcd.alu_op), 64'hd);

    exp_q = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      inst = rnd_inst();
      en   = ($urandom_range(0, 3) != 0);
      if (k % 97 == 50) begin
        rst = 1'b1;
        #1;
        chk("rst_async", dcd_q, 64'd0);
        exp_q = '0;
        // reset held across an enabled edge must still win
        @(posedge clk);
        #1;
        chk("rst_en", dcd_q, 64'd0);
        rst = 1'b0;
        @(negedge clk);
      end
      #1;
      chk("rnd_dcd", dcd, model(inst));
      @(posedge clk);
      if (en) exp_q = model(inst);
      #1;
      chk("rnd_q", dcd_q, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
